// File: rtl/tt_frame_loader_if.sv
// Word-stream handshake between a configuration source and tt_frame_loader.
//   s_data  : 32-bit configuration word (source -> loader)
//   s_valid : s_data holds a word (source -> loader)
//   s_ready : loader takes the word at the next clock edge (loader -> source)
// A word moves when s_valid && s_ready on a rising clock edge.
interface tt_frame_loader_if #(
    parameter int unsigned DataWidth = 32
);
    logic [DataWidth-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/tt_frame_loader.sv
// Configuration word loader for a two-row TinyTapeout tile column.
// Hunts for the sync word, decodes frame-address commands, collects one data
// word per row and fires a single-cycle one-hot FrameStrobe for that frame.
//
// Ports:
//   UserCLK      : clock
//   resetn       : asynchronous active-low reset
//   s            : word stream (slave side of tt_frame_loader_if)
//   FrameData    : row k = FrameData[k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  : one-hot, one-cycle frame write strobe
//   cfg_active   : high from accepted sync until the return to idle
//   cfg_done     : one-cycle pulse after an accepted desync word
//   cfg_error    : sticky protocol error, cleared by the next sync word
//   frame_count  : strobes since the last sync word, saturating at 255
module tt_frame_loader #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 2,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter logic [31:0] DesyncWord      = 32'hFAB0_FAB0
) (
    input  logic                               UserCLK,
    input  logic                               resetn,
    tt_frame_loader_if.slave                   s,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               cfg_active,
    output logic                               cfg_done,
    output logic                               cfg_error,
    output logic [7:0]                         frame_count
);

    localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StStrobe
    } state_e;

    state_e          state_q;
    logic [RowW-1:0] row_q;
    logic [4:0]      idx_q;

    logic xfer;
    logic is_sync;
    logic is_desync;
    logic addr_ok;
    logic last_row;

    // Decoded from the state register only, so no path from s_valid.
    assign s.s_ready = (state_q != StStrobe);

    assign xfer      = s.s_valid && s.s_ready;
    assign is_sync   = (s.s_data == SyncWord);
    assign is_desync = (s.s_data == DesyncWord);
    assign addr_ok   = (s.s_data[31:16] == 16'hF000) &&
                       (s.s_data[15:5] == 11'd0) &&
                       (32'(s.s_data[4:0]) < MaxFramesPerCol);
    assign last_row  = (32'(row_q) == NumRows - 1);

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            row_q       <= '0;
            idx_q       <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            cfg_active  <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_error   <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            // Both are single-cycle pulses; any state that wants them re-asserts.
            FrameStrobe <= '0;
            cfg_done    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (xfer && is_sync) begin
                        state_q     <= StAddr;
                        cfg_error   <= 1'b0;
                        frame_count <= 8'd0;
                        cfg_active  <= 1'b1;
                    end
                end

                StAddr: begin
                    if (xfer) begin
                        if (is_desync) begin
                            state_q    <= StIdle;
                            cfg_done   <= 1'b1;
                            cfg_active <= 1'b0;
                        end else if (is_sync) begin
                            frame_count <= 8'd0;
                        end else if (addr_ok) begin
                            idx_q   <= s.s_data[4:0];
                            row_q   <= '0;
                            state_q <= StData;
                        end else begin
                            cfg_error  <= 1'b1;
                            cfg_active <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                end

                StData: begin
                    // Data words are raw: markers are not decoded here.
                    if (xfer) begin
                        for (int k = 0; k < int'(NumRows); k++) begin
                            if (row_q == RowW'(k)) begin
                                FrameData[k*FrameBitsPerRow +: FrameBitsPerRow] <= s.s_data;
                            end
                        end
                        if (last_row) begin
                            // Strobe and count are registered so they appear
                            // together in the STROBE cycle.
                            for (int k = 0; k < int'(MaxFramesPerCol); k++) begin
                                FrameStrobe[k] <= (5'(k) == idx_q);
                            end
                            if (frame_count != 8'hFF) begin
                                frame_count <= frame_count + 8'd1;
                            end
                            state_q <= StStrobe;
                        end else begin
                            row_q <= row_q + RowW'(1);
                        end
                    end
                end

                StStrobe: begin
                    state_q <= StAddr;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_frame_loader.sv
// Self-checking bench for tt_frame_loader. Expected frames are derived from the
// words each scenario sends; a negedge monitor records what the DUT strobes.
module tb_tt_frame_loader;

    localparam logic [31:0] Sync   = 32'hFAB0_FAB1;
    localparam logic [31:0] Desync = 32'hFAB0_FAB0;

    logic        UserCLK = 1'b0;
    logic        resetn;
    logic [63:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        cfg_active;
    logic        cfg_done;
    logic        cfg_error;
    logic [7:0]  frame_count;

    tt_frame_loader_if bus ();

    tt_frame_loader dut (
        .UserCLK     (UserCLK),
        .resetn      (resetn),
        .s           (bus.slave),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .cfg_active  (cfg_active),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error),
        .frame_count (frame_count)
    );

    always #5 UserCLK = ~UserCLK;

    int checks = 0;
    int passes = 0;

    // Monitor: every nonzero strobe cycle, the data visible with it, done pulses.
    logic [19:0] mon_strobe[$];
    logic [63:0] mon_data[$];
    int          mon_done = 0;
    int          mon_ready_bad = 0;

    always @(negedge UserCLK) begin
        if (resetn === 1'b1 && FrameStrobe !== 20'd0) begin
            mon_strobe.push_back(FrameStrobe);
            mon_data.push_back(FrameData);
            if (bus.s_ready !== 1'b0) mon_ready_bad++;
        end
        if (resetn === 1'b1 && cfg_done === 1'b1) mon_done++;
    end

    // Expected frames for the current scenario.
    logic [19:0] exp_strobe[$];
    logic [63:0] exp_data[$];

    task automatic clear_sb();
        mon_strobe.delete();
        mon_data.delete();
        exp_strobe.delete();
        exp_data.delete();
        mon_ready_bad = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge UserCLK);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            @(negedge UserCLK);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, n);
        end
        @(negedge UserCLK);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input int idx, input logic [31:0] d0, input logic [31:0] d1,
                              input bit gaps);
        if (gaps) idle($urandom_range(0, 2));
        send(32'hF000_0000 | 32'(idx));
        if (gaps) idle($urandom_range(0, 2));
        send(d0);
        if (gaps) idle($urandom_range(0, 2));
        send(d1);
        exp_strobe.push_back(20'd1 << idx);
        exp_data.push_back({d1, d0});
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'd0;
        idle(2);
        checks++;
        if ({FrameData, FrameStrobe, cfg_active, cfg_done, cfg_error, frame_count} !== 96'd0)
            $display("FAIL reset_outputs: got data=%h strb=%h act=%b done=%b err=%b cnt=%0d want all 0",
                     FrameData, FrameStrobe, cfg_active, cfg_done, cfg_error, frame_count);
        else passes++;
        resetn = 1'b1;
        idle(1);
        checks++;
        if (bus.s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.s_ready);
        else passes++;
        checks++;
        if ({FrameStrobe, cfg_active, frame_count} !== 29'd0)
            $display("FAIL reset_release: got strb=%h act=%b cnt=%0d want 0",
                     FrameStrobe, cfg_active, frame_count);
        else passes++;
    endtask

    task automatic test_single_frame();
        clear_sb();
        send(Sync);
        checks++;
        if (cfg_active !== 1'b1) $display("FAIL sync_active: got %b want 1", cfg_active);
        else passes++;
        send(32'hF000_0003);
        send(32'h1111_1111);
        send(32'h2222_2222);
        // Cycle t+1 after the last data word.
        checks++;
        if (FrameStrobe !== 20'h00008)
            $display("FAIL single_strobe: got %h want %h", FrameStrobe, 20'h00008);
        else passes++;
        checks++;
        if (bus.s_ready !== 1'b0) $display("FAIL single_ready_low: got %b want 0", bus.s_ready);
        else passes++;
        checks++;
        if (FrameData !== 64'h2222_2222_1111_1111)
            $display("FAIL single_data: got %h want %h", FrameData, 64'h2222_2222_1111_1111);
        else passes++;
        idle(1);
        checks++;
        if (FrameStrobe !== 20'd0) $display("FAIL single_strobe_len: got %h want 0", FrameStrobe);
        else passes++;
        checks++;
        if (FrameData !== 64'h2222_2222_1111_1111)
            $display("FAIL single_data_hold: got %h want %h", FrameData, 64'h2222_2222_1111_1111);
        else passes++;
        checks++;
        if (frame_count !== 8'd1) $display("FAIL single_count: got %0d want 1", frame_count);
        else passes++;
        checks++;
        if (bus.s_ready !== 1'b1) $display("FAIL single_ready_back: got %b want 1", bus.s_ready);
        else passes++;
    endtask

    task automatic compare_frames(input string name);
        checks++;
        if (mon_strobe.size() !== exp_strobe.size())
            $display("FAIL %s_nframes: got %0d want %0d", name, mon_strobe.size(),
                     exp_strobe.size());
        else passes++;
        for (int i = 0; i < exp_strobe.size() && i < mon_strobe.size(); i++) begin
            checks++;
            if (mon_strobe[i] !== exp_strobe[i] || mon_data[i] !== exp_data[i])
                $display("FAIL %s_frame%0d: got strb=%h data=%h want strb=%h data=%h", name, i,
                         mon_strobe[i], mon_data[i], exp_strobe[i], exp_data[i]);
            else passes++;
        end
        checks++;
        if (mon_ready_bad !== 0)
            $display("FAIL %s_ready_in_strobe: got %0d cycles want 0", name, mon_ready_bad);
        else passes++;
    endtask

    task automatic test_full_column();
        int done0;
        clear_sb();
        idle($urandom_range(0, 3));
        send(Sync);
        for (int i = 0; i < 20; i++) send_frame(i, $urandom, $urandom, 1'b1);
        idle($urandom_range(0, 3));
        done0 = mon_done;
        send(Desync);
        checks++;
        if (cfg_done !== 1'b1 || cfg_active !== 1'b0)
            $display("FAIL column_done: got done=%b act=%b want done=1 act=0", cfg_done,
                     cfg_active);
        else passes++;
        idle(1);
        checks++;
        if (cfg_done !== 1'b0) $display("FAIL column_done_len: got %b want 0", cfg_done);
        else passes++;
        checks++;
        if (frame_count !== 8'd20) $display("FAIL column_count: got %0d want 20", frame_count);
        else passes++;
        checks++;
        if (mon_done - done0 !== 1)
            $display("FAIL column_done_pulses: got %0d want 1", mon_done - done0);
        else passes++;
        compare_frames("column");
    endtask

    task automatic test_bad_address();
        clear_sb();
        send(Sync);
        send(32'hF000_0014);
        checks++;
        if (cfg_error !== 1'b1 || cfg_active !== 1'b0)
            $display("FAIL badaddr_error: got err=%b act=%b want err=1 act=0", cfg_error,
                     cfg_active);
        else passes++;
        // Looks like a frame, but loader is idle and must ignore it.
        send(32'hF000_0002);
        send(32'h1234_5678);
        send(32'h9ABC_DEF0);
        idle(3);
        checks++;
        if (mon_strobe.size() !== 0)
            $display("FAIL badaddr_nostrobe: got %0d strobes want 0", mon_strobe.size());
        else passes++;
        checks++;
        if (cfg_error !== 1'b1 || frame_count !== 8'd0)
            $display("FAIL badaddr_sticky: got err=%b cnt=%0d want err=1 cnt=0", cfg_error,
                     frame_count);
        else passes++;
        send(Sync);
        checks++;
        if (cfg_error !== 1'b0 || cfg_active !== 1'b1)
            $display("FAIL badaddr_resync: got err=%b act=%b want err=0 act=1", cfg_error,
                     cfg_active);
        else passes++;
        send(Desync);
    endtask

    // Random address words judged by the address rule alone.
    task automatic test_random_address();
        logic [31:0] w;
        bit          valid;
        for (int it = 0; it < 12; it++) begin
            clear_sb();
            if (it % 2 == 0) w = 32'hF000_0000 | 32'($urandom_range(0, 40));
            else             w = $urandom;
            if (w == Sync || w == Desync) w = 32'h0000_0001;
            valid = (w >> 16) == 32'hF000 && (w & 32'hFFFF) < 32'd20;
            send(Sync);
            send(w);
            if (valid) begin
                logic [31:0] d0;
                logic [31:0] d1;
                d0 = $urandom;
                d1 = $urandom;
                send(d0);
                send(d1);
                exp_strobe.push_back(20'd1 << (w & 32'h1F));
                exp_data.push_back({d1, d0});
                idle(1);
                send(Desync);
            end
            idle(1);
            checks++;
            if (cfg_error !== !valid)
                $display("FAIL randaddr_error: word %h got err=%b want %b", w, cfg_error, !valid);
            else passes++;
            compare_frames("randaddr");
        end
    endtask

    task automatic test_marker_data();
        int done0;
        clear_sb();
        send(Sync);
        done0 = mon_done;
        send_frame(7, Desync, Sync, 1'b0);
        send_frame(1, 32'hCAFE_0001, 32'hCAFE_0002, 1'b0);
        idle(1);
        checks++;
        if (mon_done !== done0 || cfg_active !== 1'b1)
            $display("FAIL markers_nodone: got done_pulses=%0d act=%b want 0 and 1",
                     mon_done - done0, cfg_active);
        else passes++;
        checks++;
        if (frame_count !== 8'd2) $display("FAIL markers_count: got %0d want 2", frame_count);
        else passes++;
        compare_frames("markers");
        send(Desync);
    endtask

    task automatic test_reset_in_data();
        clear_sb();
        send(Sync);
        send(32'hF000_0005);
        send(32'hDEAD_BEEF);
        resetn = 1'b0;
        #2;
        checks++;
        if (FrameData !== 64'd0 || FrameStrobe !== 20'd0 || bus.s_ready !== 1'b1)
            $display("FAIL rstdata_cut: got data=%h strb=%h rdy=%b want 0/0/1", FrameData,
                     FrameStrobe, bus.s_ready);
        else passes++;
        @(negedge UserCLK);
        resetn = 1'b1;
        send(32'h5555_5555);
        idle(4);
        checks++;
        if (mon_strobe.size() !== 0 || FrameData !== 64'd0)
            $display("FAIL rstdata_nostrobe: got %0d strobes data=%h want 0 and 0",
                     mon_strobe.size(), FrameData);
        else passes++;
        send(Sync);
        send_frame(5, 32'hAAAA_0000, 32'hBBBB_1111, 1'b0);
        idle(1);
        checks++;
        if (frame_count !== 8'd1) $display("FAIL rstdata_count: got %0d want 1", frame_count);
        else passes++;
        compare_frames("rstdata");
        // Reset landing on the strobe cycle must kill the strobe at once.
        send_frame(9, 32'h0000_0009, 32'h0000_0090, 1'b0);
        resetn = 1'b0;
        #1;
        checks++;
        if (FrameStrobe !== 20'd0 || frame_count !== 8'd0)
            $display("FAIL rststrobe_cut: got strb=%h cnt=%0d want 0", FrameStrobe, frame_count);
        else passes++;
        @(negedge UserCLK);
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_back_to_back_saturate();
        clear_sb();
        send(Sync);
        for (int i = 0; i < 255; i++) send_frame(i % 20, $urandom, $urandom, 1'b0);
        idle(1);
        checks++;
        if (frame_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", frame_count);
        else passes++;
        for (int i = 0; i < 5; i++) send_frame(19 - i, $urandom, $urandom, 1'b0);
        idle(1);
        checks++;
        if (frame_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", frame_count);
        else passes++;
        compare_frames("b2b");
        send(Sync);
        idle(1);
        checks++;
        if (frame_count !== 8'd0) $display("FAIL resync_count: got %0d want 0", frame_count);
        else passes++;
        send(Desync);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        send(Desync);
        test_full_column();
        test_bad_address();
        test_random_address();
        test_marker_data();
        test_reset_in_data();
        test_back_to_back_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
